// File: rtl/seg_scan_display_pkg.sv
// Shared definitions for the BCD converter and the multiplexed 7-segment scanner.
// Segment patterns are active-low and ordered {g,f,e,d,c,b,a}.
package seg_scan_display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } conv_state_t;

    localparam int          BIN_W       = 8;
    localparam int          BCD_W       = 12;
    localparam logic [2:0]  SHIFT_LAST  = 3'd7;

    localparam logic [6:0]  SEG_BLANK   = 7'b111_1111;
    localparam logic [3:0]  AN_OFF      = 4'b1111;
    localparam logic [3:0]  AN_SLOT0    = 4'b1110;
    localparam logic [3:0]  AN_SLOT1    = 4'b1101;
    localparam logic [3:0]  AN_SLOT2    = 4'b1011;

    // Entry [d] is the pattern for decimal digit d.
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

    function automatic logic [6:0] seg_encode(input logic [3:0] digit);
        logic [6:0] pattern;
        pattern = SEG_BLANK;
        if (digit <= 4'd9) begin
            pattern = SEG_TABLE[digit];
        end
        return pattern;
    endfunction

    // Double-dabble correction applied to each BCD nibble before a shift.
    function automatic logic [3:0] bcd_adjust(input logic [3:0] nibble);
        logic [3:0] result;
        result = nibble;
        if (nibble >= 4'd5) begin
            result = nibble + 4'd3;
        end
        return result;
    endfunction

endpackage

// File: rtl/seg_scan_display_bin2bcd.sv
// Sequential 8-bit binary to 3-digit BCD converter (double-dabble, one bit per clock).
//   state    | meaning
//   ST_IDLE  | waiting for bin to differ from the last converted value
//   ST_SHIFT | 8 adjust-and-shift steps, step_cnt counts down to 0
//   ST_DONE  | one cycle, publishes the result to bcd
module bin2bcd_seq
    import seg_scan_display_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic [BIN_W-1:0]  bin,
    output logic              busy,
    output logic [BCD_W-1:0]  bcd
);

    conv_state_t        state;
    conv_state_t        state_next;
    logic [BIN_W-1:0]   last_val;
    logic [BIN_W-1:0]   shreg;
    logic [BCD_W-1:0]   acc;
    logic [BCD_W-1:0]   acc_adj;
    logic [2:0]         step_cnt;
    logic               start;

    assign start = (bin != last_val);
    assign busy  = (state != ST_IDLE);

    assign acc_adj = {bcd_adjust(acc[11:8]), bcd_adjust(acc[7:4]), bcd_adjust(acc[3:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (start) state_next = ST_SHIFT;
            ST_SHIFT: if (step_cnt == 3'd0) state_next = ST_DONE;
            ST_DONE:  state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // bcd doubles as the display register and only moves in ST_DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_val <= '0;
            shreg    <= '0;
            acc      <= '0;
            step_cnt <= '0;
            bcd      <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        last_val <= bin;
                        shreg    <= bin;
                        acc      <= '0;
                        step_cnt <= SHIFT_LAST;
                    end
                end
                ST_SHIFT: begin
                    acc      <= {acc_adj[BCD_W-2:0], shreg[BIN_W-1]};
                    shreg    <= {shreg[BIN_W-2:0], 1'b0};
                    step_cnt <= step_cnt - 3'd1;
                end
                ST_DONE: begin
                    bcd <= acc;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/seg_scan_display.sv
// Displays an 8-bit count as up to three decimal digits on a multiplexed,
// active-low 7-segment display with leading-zero blanking.
module seg_scan_display
    import seg_scan_display_pkg::*;
#(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  val_in,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        busy
);

    localparam int                PRE_W    = $clog2(REFRESH_DIV);
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [PRE_W-1:0]  prescaler;
    logic [1:0]        scan_idx;
    logic [BCD_W-1:0]  bcd;
    logic [3:0]        hundreds;
    logic [3:0]        tens;
    logic [3:0]        ones;
    logic [3:0]        an_next;
    logic [6:0]        seg_next;

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .bin   (val_in),
        .busy  (busy),
        .bcd   (bcd)
    );

    assign hundreds = bcd[11:8];
    assign tens     = bcd[7:4];
    assign ones     = bcd[3:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            prescaler <= '0;
            scan_idx  <= 2'd0;
        end else if (prescaler == PRE_LAST) begin
            prescaler <= '0;
            scan_idx  <= (scan_idx == 2'd2) ? 2'd0 : scan_idx + 2'd1;
        end else begin
            prescaler <= prescaler + PRE_W'(1);
        end
    end

    // Tens is shown whenever hundreds is, even when tens itself is zero.
    always_comb begin
        an_next  = AN_OFF;
        seg_next = SEG_BLANK;
        case (scan_idx)
            2'd0: begin
                an_next  = AN_SLOT0;
                seg_next = seg_encode(ones);
            end
            2'd1: begin
                if ((hundreds != 4'd0) || (tens != 4'd0)) begin
                    an_next  = AN_SLOT1;
                    seg_next = seg_encode(tens);
                end
            end
            2'd2: begin
                if (hundreds != 4'd0) begin
                    an_next  = AN_SLOT2;
                    seg_next = seg_encode(hundreds);
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            an  <= AN_OFF;
            seg <= SEG_BLANK;
        end else begin
            an  <= an_next;
            seg <= seg_next;
        end
    end

endmodule

// File: tb/tb_seg_scan_display.sv
// Scoreboard bench for seg_scan_display with REFRESH_DIV=4: stimulus queues
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_seg_scan_display;

    localparam logic [6:0] D0 = 7'b1000000;
    localparam logic [6:0] D1 = 7'b1111001;
    localparam logic [6:0] D2 = 7'b0100100;
    localparam logic [6:0] D4 = 7'b0011001;
    localparam logic [6:0] D5 = 7'b0010010;
    localparam logic [6:0] D7 = 7'b1111000;
    localparam logic [6:0] BL = 7'b1111111;

    typedef struct {
        int          cyc;
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        busy;
        bit          chk_disp;
        bit          chk_busy;
        string       tag;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  val_in = 8'd0;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        busy;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    seg_scan_display #(.REFRESH_DIV(4)) dut (
        .clk    (clk),
        .reset  (reset),
        .val_in (val_in),
        .an     (an),
        .seg    (seg),
        .busy   (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic wait_cyc(input int n);
        while (cyc < n) @(negedge clk);
    endtask

    task automatic push_busy(input int from, input int to, input logic b, input string tag);
        for (int n = from; n <= to; n++) begin
            exp_t e;
            e.cyc = n; e.an = 4'b0; e.seg = 7'b0; e.busy = b;
            e.chk_disp = 1'b0; e.chk_busy = 1'b1; e.tag = tag;
            sb.push_back(e);
        end
    endtask

    task automatic push_raw(input int n, input logic [3:0] a, input logic [6:0] s, input string tag);
        exp_t e;
        e.cyc = n; e.an = a; e.seg = s; e.busy = 1'b0;
        e.chk_disp = 1'b1; e.chk_busy = 1'b0; e.tag = tag;
        sb.push_back(e);
    endtask

    // rel is the cycle at whose negedge reset was released; slots last 4 cycles.
    task automatic push_disp(input int from, input int to, input int rel,
                             input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input bit bl1, input bit bl2, input string tag);
        for (int n = from; n <= to; n++) begin
            int slot;
            slot = ((n - rel - 1) / 4) % 3;
            case (slot)
                0:       push_raw(n, 4'b1110, s0, tag);
                1:       push_raw(n, bl1 ? 4'b1111 : 4'b1101, bl1 ? BL : s1, tag);
                default: push_raw(n, bl2 ? 4'b1111 : 4'b1011, bl2 ? BL : s2, tag);
            endcase
        end
    endtask

    // Monitor: compares every expectation due this cycle, flags any left behind.
    initial begin
        forever begin
            @(negedge clk);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    checks++;
                    if (sb[i].chk_disp && (an !== sb[i].an || seg !== sb[i].seg)) begin
                        errors++;
                        $display("FAIL %s cyc=%0d: an=%b seg=%b, expected an=%b seg=%b",
                                 sb[i].tag, cyc, an, seg, sb[i].an, sb[i].seg);
                    end
                    if (sb[i].chk_busy && busy !== sb[i].busy) begin
                        errors++;
                        $display("FAIL %s cyc=%0d: busy=%b, expected %b",
                                 sb[i].tag, cyc, busy, sb[i].busy);
                    end
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: expectation for cyc=%0d never compared", sb[i].tag, sb[i].cyc);
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached at cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        int rel;

        // Reset with val_in=0, then the first scan rotation showing a lone "0".
        push_raw(2, 4'b1111, BL, "reset_hold");
        push_raw(3, 4'b1111, BL, "reset_hold");
        push_busy(2, 3, 1'b0, "reset_busy");
        push_disp(5, 16, 4, D0, BL, BL, 1'b1, 1'b1, "post_reset_scan");
        push_busy(5, 16, 1'b0, "post_reset_busy");
        wait_cyc(4);
        reset = 1'b0;
        rel = 4;

        // 0 -> 255
        wait_cyc(17);
        c = cyc;
        val_in = 8'd255;
        push_busy(c + 1, c + 9, 1'b1, "busy_255");
        push_busy(c + 10, c + 10, 1'b0, "idle_255");
        push_disp(c + 11, c + 22, rel, D5, D5, D2, 1'b0, 1'b0, "show_255");

        // 7: tens and hundreds blanked
        wait_cyc(c + 23);
        c = cyc;
        val_in = 8'd7;
        push_busy(c + 1, c + 9, 1'b1, "busy_7");
        push_busy(c + 10, c + 10, 1'b0, "idle_7");
        push_disp(c + 11, c + 22, rel, D7, BL, BL, 1'b1, 1'b1, "show_7");

        // 100, then 42 while busy: 42 converts right after the first finishes
        wait_cyc(c + 23);
        c = cyc;
        val_in = 8'd100;
        push_busy(c + 1, c + 9, 1'b1, "busy_100");
        push_busy(c + 10, c + 10, 1'b0, "idle_gap");
        push_busy(c + 11, c + 19, 1'b1, "busy_42");
        push_busy(c + 20, c + 20, 1'b0, "idle_42");
        push_disp(c + 11, c + 20, rel, D0, D0, D1, 1'b0, 1'b0, "show_100");
        push_disp(c + 21, c + 32, rel, D2, D4, BL, 1'b0, 1'b1, "show_42");
        wait_cyc(c + 3);
        val_in = 8'd42;

        // 200 with a reset pulse in the 4th SHIFT cycle, then 36-cycle scan check
        wait_cyc(c + 33);
        c = cyc;
        val_in = 8'd200;
        rel = c + 5;
        push_busy(c + 1, c + 4, 1'b1, "busy_200_pre");
        push_raw(c + 5, 4'b1111, BL, "abort_reset");
        push_busy(c + 5, c + 5, 1'b0, "abort_busy");
        push_busy(c + 6, c + 14, 1'b1, "busy_200");
        push_busy(c + 15, c + 15, 1'b0, "idle_200");
        push_disp(c + 6, c + 15, rel, D0, BL, BL, 1'b1, 1'b1, "hold_zero");
        push_disp(c + 16, c + 51, rel, D0, D0, D2, 1'b0, 1'b0, "scan_200");
        wait_cyc(c + 4);
        reset = 1'b1;
        wait_cyc(c + 5);
        reset = 1'b0;

        wait_cyc(c + 54);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg_scan_display.md
SEG_SCAN_DISPLAY -- requirements
Module: seg_scan_display

Purpose: downstream stage of the 8-bit up/down counter. Converts the unsigned count to BCD and drives a multiplexed, active-low, 4-anode 7-segment display.

Interface
REQ-001 Parameter REFRESH_DIV, default 100000, clk cycles each digit slot is held (≥2; benches use 4).
REQ-002 Port clk  input  1  system clock; all logic on its rising edge.
REQ-003 Port reset  input  1  synchronous, active-high reset.
REQ-004 Port val_in  input  8  unsigned count to display (0..255).
REQ-005 Port an  output  4  anode enables, active-low; an[3] is unused and held 1.
REQ-006 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-007 Port busy  output  1  high while a BCD conversion is in progress.

Function
REQ-008 Converter FSM SHALL have states IDLE, SHIFT, DONE.
REQ-009 In IDLE, if val_in != last_val, the block SHALL latch val_in into last_val and the shift register, clear the BCD accumulator, and enter SHIFT; otherwise it SHALL stay in IDLE.
REQ-010 SHIFT SHALL run exactly 8 cycles of double-dabble (add 3 to any BCD nibble ≥5, then shift left 1) and then enter DONE.
REQ-011 DONE SHALL last 1 cycle, write hundreds/tens/ones display registers, and return to IDLE.
REQ-012 busy SHALL be 1 in SHIFT and DONE (9 cycles per conversion) and 0 in IDLE.
REQ-013 val_in changes during busy SHALL be ignored until IDLE, where the mismatch check starts a new conversion of the then-current val_in; intermediate values may never be shown.
REQ-014 Display registers SHALL change only in DONE; digits never show partial results.
REQ-015 A prescaler SHALL count 0..REFRESH_DIV-1 and wrap; at wrap the scan index SHALL advance 0→1→2→0.
REQ-016 Slot 0 = ones, slot 1 = tens, slot 2 = hundreds; the active slot drives an[k]=0 and the other anodes 1.
REQ-017 Leading-zero blanking: hundreds blank if 0; tens blank if hundreds and tens are both 0; ones never blank.
REQ-018 In a blanked slot, an SHALL be 4'b1111 and seg SHALL be 7'b1111111.
REQ-019 an and seg SHALL be registered, lagging scan index and display registers by 1 cycle.
REQ-020 Seg patterns: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.

Reset
REQ-021 While reset is 1: state IDLE, last_val=0, display registers=0, prescaler=0, scan index=0, busy=0, an=1111, seg=1111111.
REQ-022 Reset mid-conversion SHALL abort it with no display update; after release, a nonzero val_in SHALL start a fresh conversion from the next IDLE cycle.
REQ-023 In the first cycle after release, an=1110 and seg=1000000 (digit "0").

Structure
REQ-024 A shared package SHALL hold the FSM state encoding, the seg pattern table for 0-9, and the SEG_BLANK constant.
REQ-025 The converter SHALL be the sub-module bin2bcd_seq (ports clk, reset, bin, busy, bcd[11:0]); scanning and encoding stay in seg_scan_display.
REQ-026 Prescaler width SHALL be $clog2(REFRESH_DIV).

Verification (REFRESH_DIV=4)
REQ-027 Reset with val_in=0 -> an=1111 and seg=1111111 during reset; then an cycles 1110 (seg 1000000), 1111, 1111, with each slot held 4 cycles.
REQ-028 val_in steps 0→255 -> busy=1 for exactly 9 cycles; then slots show 5,5,2 (0010010, 0010010, 0100100).
REQ-029 val_in=7 -> slot 0 shows 1111000; slots 1 and 2 show an=1111 and seg=1111111.
REQ-030 val_in=100, then 42 three cycles later -> display shows 1,0,0 first; a second 9-cycle busy follows; final display shows blank, 4, 2.
REQ-031 Reset pulsed in cycle 4 of the SHIFT for val_in=200 -> display stays 0, busy drops to 0; after release, 2,0,0 appears 10 cycles later.
REQ-032 Scan wrap check: over 36 cycles the an sequence repeats exactly with period 12, an[3] always 1.
